// File: rtl/segment_stepper_pkg.sv
// Shared definitions for the segment stepper: controller state encoding,
// motion-record field layout and the effective-period helper.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIR_SETUP = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } state_e;

    // Motion record layout (word 0 in bits [7:0]).
    localparam int COUNT_LSB  = 0;
    localparam int PERIOD_LSB = 32;
    localparam int DIR_BIT    = 64;
    localparam int FIELD_W    = 32;

    // Period is clamped so the low phase is never shorter than the high phase.
    // The floor is formed one bit wider so 2*pulse_cycles cannot wrap.
    function automatic logic [FIELD_W-1:0] eff_period(input logic [FIELD_W-1:0] period,
                                                      input int pulse_cycles);
        logic [FIELD_W:0] per_w;
        logic [FIELD_W:0] floor_w;
        per_w   = {1'b0, period};
        floor_w = (FIELD_W+1)'(2 * pulse_cycles);
        return (per_w > floor_w) ? per_w[FIELD_W-1:0] : floor_w[FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/segment_stepper_if.sv
// Record FIFO read port.
//   master : consumer side (segment_stepper) - sees empty/data, drives read_en
//   slave  : FIFO side                      - drives empty/data, sees read_en
interface segment_stepper_if #(
    parameter int RECORD_BITS = 128
) ();
    logic                   fifo_empty;
    logic [RECORD_BITS-1:0] fifo_data;
    logic                   fifo_read_en;

    modport master (input fifo_empty, input fifo_data, output fifo_read_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_read_en);
endinterface

// File: rtl/segment_stepper_pulse_timer.sv
// Loadable 32-bit down-counter used to time every controller phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i this cycle (wins over hold_i)
//   hold_i      : freeze the count
//   load_val_i  : value loaded; phase length is load_val_i + 1 cycles
//   zero_o      : count has reached zero
module pulse_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        hold_i,
    input  logic [31:0] load_val_i,
    output logic        zero_o
);
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (!hold_i && cnt_q != '0)
            cnt_d = cnt_q - 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/segment_stepper.sv
// Single-axis step/direction generator. Pops one motion record at a time from
// the record FIFO and plays it out as timed step pulses.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : run when high; low freezes timing (a high pulse still completes)
//   fifo            : record FIFO read port (master modport)
//   step, dir       : registered driver pins
//   busy            : segment in progress
//   segment_done    : one-cycle pulse in the first IDLE cycle after a segment
//   steps_remaining : pulses still to be issued in the current segment
module segment_stepper
    import stepper_pkg::*;
#(
    parameter int RECORD_BITS      = 128,
    parameter int PULSE_CYCLES     = 4,
    parameter int DIR_SETUP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    segment_stepper_if.master  fifo,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               segment_done,
    output logic [31:0]        steps_remaining
);
    // Timer reload values: a phase of N cycles loads N-1.
    localparam logic [31:0] SETUP_LD = 32'(DIR_SETUP_CYCLES - 1);
    localparam logic [31:0] HIGH_LD  = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] PULSE_W  = 32'(PULSE_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] per_q, per_d;
    logic        dir_q, dir_d;
    logic        step_q, step_d;
    logic        done_q, done_d;
    logic        pop;
    logic        tmr_load, tmr_hold, tmr_zero;
    logic [31:0] tmr_val;

    logic unused_rsvd;
    assign unused_rsvd = ^fifo.fifo_data[RECORD_BITS-1:DIR_BIT+1];

    assign pop               = rst_n & enable & ~fifo.fifo_empty & (state_q == IDLE);
    assign fifo.fifo_read_en = pop;

    // A high pulse always runs to completion; every other phase freezes.
    assign tmr_hold = !enable && (state_q != STEP_HIGH);

    pulse_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .hold_i     (tmr_hold),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        per_d    = per_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d  = DIR_SETUP;
                    rem_d    = fifo.fifo_data[COUNT_LSB +: FIELD_W];
                    per_d    = eff_period(fifo.fifo_data[PERIOD_LSB +: FIELD_W], PULSE_CYCLES);
                    dir_d    = fifo.fifo_data[DIR_BIT];
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            // Both phases end the same way: next pulse if any remain, else done.
            // A zero-count record therefore exits straight from DIR_SETUP.
            DIR_SETUP, STEP_LOW: begin
                if (enable && tmr_zero) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = STEP_HIGH;
                        step_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = HIGH_LD;
                    end
                end
            end
            STEP_HIGH: begin
                if (tmr_zero) begin
                    state_d  = STEP_LOW;
                    rem_d    = rem_q - 32'd1;
                    tmr_load = 1'b1;
                    tmr_val  = per_q - PULSE_W - 32'd1;
                end else begin
                    step_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            per_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            per_q   <= per_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign step            = step_q;
    assign dir             = dir_q;
    assign busy            = (state_q != IDLE);
    assign segment_done    = done_q;
    assign steps_remaining = rem_q;
endmodule

// File: tb/tb_segment_stepper.sv
module tb_segment_stepper;
    localparam int PW   = 4;
    localparam int DS   = 2;
    localparam int HMAX = 32768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        step, dir, busy, segment_done;
    logic [31:0] steps_remaining;

    segment_stepper_if #(.RECORD_BITS(128)) fif ();

    segment_stepper #(.RECORD_BITS(128), .PULSE_CYCLES(PW), .DIR_SETUP_CYCLES(DS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .fifo            (fif),
        .step            (step),
        .dir             (dir),
        .busy            (busy),
        .segment_done    (segment_done),
        .steps_remaining (steps_remaining)
    );

    always #5 clk = ~clk;

    int           n_chk = 0, n_pass = 0, cyc = 0;
    logic [127:0] fq[$];
    bit           pop_armed = 0, prev_step = 0;
    // Events are encoded as cycle*4 + kind (0 pop, 1 rise, 2 fall, 3 done).
    longint       ev_q[$], exp_q[$];
    logic [31:0]  rem_h  [0:HMAX-1];
    logic         dir_h  [0:HMAX-1];
    logic         busy_h [0:HMAX-1];

    // FIFO model: pop one record after any edge that saw fifo_read_en.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pop_armed && fq.size() > 0) void'(fq.pop_front());
        pop_armed = 0;
        fif.fifo_empty = (fq.size() == 0);
        fif.fifo_data  = (fq.size() > 0) ? fq[0] : '0;
    end

    // Monitor: sample outputs mid-cycle, after edge number cyc.
    always @(negedge clk) begin
        if (cyc < HMAX) begin
            rem_h[cyc]  = steps_remaining;
            dir_h[cyc]  = dir;
            busy_h[cyc] = busy;
        end
        if (step && !prev_step) ev_q.push_back(longint'(cyc) * 4 + 1);
        if (!step && prev_step) ev_q.push_back(longint'(cyc) * 4 + 2);
        if (segment_done)       ev_q.push_back(longint'(cyc) * 4 + 3);
        if (fif.fifo_read_en) begin
            pop_armed = 1;
            ev_q.push_back(longint'(cyc + 1) * 4);
        end
        prev_step = step;
    end

    // Reference: a record popped on edge p rises at p+DS+i*eff, falls PW later,
    // and reports done at p+DS+count*eff. Returns the done edge.
    function automatic int model_seg(input logic [127:0] r, input int p);
        longint eff, cnt, t;
        eff = longint'(r[63:32]);
        cnt = longint'(r[31:0]);
        if (eff < 2 * PW) eff = 2 * PW;
        exp_q.push_back(longint'(p) * 4);
        for (longint i = 0; i < cnt; i++) begin
            t = p + DS + i * eff;
            exp_q.push_back(t * 4 + 1);
            exp_q.push_back((t + PW) * 4 + 2);
        end
        t = p + DS + cnt * eff;
        exp_q.push_back(t * 4 + 3);
        return int'(t);
    endfunction

    function automatic logic [127:0] mkrec(input int cnt, input int per, input bit d);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        r[31:0]  = cnt;
        r[63:32] = per;
        r[64]    = d;
        return r;
    endfunction

    task automatic push(input logic [127:0] r);
        fq.push_back(r);
        fif.fifo_empty = 1'b0;
        fif.fifo_data  = fq[0];
    endtask

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 1;
        run_to(cyc + 3);
        push(mkrec(5, 10, 1));
        #2;
        n_chk++; if (step !== 1'b0) $display("FAIL reset_step got %0b want 0", step); else n_pass++;
        n_chk++; if (dir !== 1'b0) $display("FAIL reset_dir got %0b want 0", dir); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_chk++; if (segment_done !== 1'b0) $display("FAIL reset_done got %0b want 0", segment_done); else n_pass++;
        n_chk++; if (steps_remaining !== 32'd0) $display("FAIL reset_rem got %0d want 0", steps_remaining); else n_pass++;
        n_chk++; if (fif.fifo_read_en !== 1'b0) $display("FAIL reset_read_en got %0b want 0", fif.fifo_read_en); else n_pass++;
        fq.delete();
        fif.fifo_empty = 1'b1;
        fif.fifo_data  = '0;
        run_to(cyc + 1);
        rst_n = 1;
        ev_q.delete();
        run_to(cyc + 100);
        n_chk++; if (ev_q.size() != 0) $display("FAIL idle_events got %0d want 0", ev_q.size()); else n_pass++;
        n_chk++; if (busy !== 1'b0 || step !== 1'b0) $display("FAIL idle_busy_step got %0b%0b want 00", busy, step); else n_pass++;
        n_chk++; if (steps_remaining !== 32'd0) $display("FAIL idle_rem got %0d want 0", steps_remaining); else n_pass++;
    endtask

    task automatic test_single(input string nm, input int cnt, input int per, input bit d);
        logic [127:0] r;
        int p, dn, eff, f;
        ev_q.delete(); exp_q.delete();
        r   = mkrec(cnt, per, d);
        eff = (per < 2 * PW) ? 2 * PW : per;
        p   = cyc + 1;
        push(r);
        dn  = model_seg(r, p);
        run_to(dn + 3);
        ev_q.sort(); exp_q.sort();
        n_chk++; if (ev_q.size() != exp_q.size()) $display("FAIL %s_evcount got %0d want %0d", nm, ev_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_chk++;
            if (ev_q[i] !== exp_q[i])
                $display("FAIL %s_ev%0d got cyc %0d kind %0d want cyc %0d kind %0d", nm, i, ev_q[i] / 4, ev_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
            else n_pass++;
        end
        n_chk++; if (dir_h[p] !== d) $display("FAIL %s_dir got %0b want %0b", nm, dir_h[p], d); else n_pass++;
        n_chk++; if (rem_h[p] !== 32'(cnt)) $display("FAIL %s_rem_load got %0d want %0d", nm, rem_h[p], cnt); else n_pass++;
        n_chk++; if (busy_h[dn - 1] !== 1'b1 || busy_h[dn] !== 1'b0) $display("FAIL %s_busy_end got %0b%0b want 10", nm, busy_h[dn - 1], busy_h[dn]); else n_pass++;
        for (int i = 0; i < cnt; i++) begin
            f = p + DS + i * eff + PW;
            n_chk++;
            if (rem_h[f] !== 32'(cnt - 1 - i) || rem_h[f - 1] !== 32'(cnt - i))
                $display("FAIL %s_rem_step%0d got %0d,%0d want %0d,%0d", nm, i, rem_h[f - 1], rem_h[f], cnt - i, cnt - 1 - i);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] r1, r2;
        int p1, p2, d2;
        ev_q.delete(); exp_q.delete();
        r1 = mkrec(2, 10, 1'b0);
        r2 = mkrec(1, 10, 1'b1);
        p1 = cyc + 1;
        push(r1); push(r2);
        p2 = model_seg(r1, p1) + 1;
        d2 = model_seg(r2, p2);
        run_to(d2 + 3);
        ev_q.sort(); exp_q.sort();
        n_chk++; if (ev_q.size() != exp_q.size()) $display("FAIL b2b_evcount got %0d want %0d", ev_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_chk++;
            if (ev_q[i] !== exp_q[i])
                $display("FAIL b2b_ev%0d got cyc %0d kind %0d want cyc %0d kind %0d", i, ev_q[i] / 4, ev_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
            else n_pass++;
        end
        n_chk++; if (dir_h[p2 - 1] !== 1'b0 || dir_h[p2] !== 1'b1) $display("FAIL b2b_dir_flip got %0b%0b want 01", dir_h[p2 - 1], dir_h[p2]); else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] r;
        int p, dn, cnts[$], dirs[$], pops[$];
        ev_q.delete(); exp_q.delete();
        p = cyc + 1;
        for (int k = 0; k < 12; k++) begin
            r = mkrec($urandom_range(0, 4), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            push(r);
            pops.push_back(p);
            cnts.push_back(int'(r[31:0]));
            dirs.push_back(int'(r[64]));
            dn = model_seg(r, p);
            p  = dn + 1;
        end
        run_to(dn + 3);
        ev_q.sort(); exp_q.sort();
        n_chk++; if (ev_q.size() != exp_q.size()) $display("FAIL rand_evcount got %0d want %0d", ev_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_chk++;
            if (ev_q[i] !== exp_q[i])
                $display("FAIL rand_ev%0d got cyc %0d kind %0d want cyc %0d kind %0d", i, ev_q[i] / 4, ev_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
            else n_pass++;
        end
        for (int k = 0; k < pops.size(); k++) begin
            n_chk++;
            if (rem_h[pops[k]] !== 32'(cnts[k]) || dir_h[pops[k]] !== 1'(dirs[k]))
                $display("FAIL rand_load%0d got rem %0d dir %0b want rem %0d dir %0d", k, rem_h[pops[k]], dir_h[pops[k]], cnts[k], dirs[k]);
            else n_pass++;
        end
    endtask

    task automatic test_enable_reset();
        logic [127:0] r;
        int p, dn;
        ev_q.delete(); exp_q.delete();
        r = mkrec(3, 10, 1'b1);
        p = cyc + 1;
        push(r);
        run_to(p + 3);
        enable = 0;
        run_to(p + 30);
        exp_q.push_back(longint'(p) * 4);
        exp_q.push_back(longint'(p + DS) * 4 + 1);
        exp_q.push_back(longint'(p + DS + PW) * 4 + 2);
        ev_q.sort();
        n_chk++; if (ev_q.size() != exp_q.size()) $display("FAIL hold_evcount got %0d want %0d", ev_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_chk++;
            if (ev_q[i] !== exp_q[i])
                $display("FAIL hold_ev%0d got cyc %0d kind %0d want cyc %0d kind %0d", i, ev_q[i] / 4, ev_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
            else n_pass++;
        end
        n_chk++; if (busy !== 1'b1 || step !== 1'b0 || steps_remaining !== 32'd2)
            $display("FAIL hold_state got busy %0b step %0b rem %0d want 1 0 2", busy, step, steps_remaining); else n_pass++;
        #2;
        rst_n = 0;
        #1;
        n_chk++; if (step !== 1'b0 || busy !== 1'b0 || dir !== 1'b0 || segment_done !== 1'b0 || steps_remaining !== 32'd0 || fif.fifo_read_en !== 1'b0)
            $display("FAIL async_reset got step %0b busy %0b dir %0b done %0b rem %0d rd %0b want all 0", step, busy, dir, segment_done, steps_remaining, fif.fifo_read_en);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        ev_q.delete(); exp_q.delete();
        run_to(cyc + 10);
        n_chk++; if (ev_q.size() != 0) $display("FAIL no_replay got %0d events want 0", ev_q.size()); else n_pass++;
        r = mkrec(1, 9, 1'b0);
        push(r);
        run_to(cyc + 10);
        n_chk++; if (ev_q.size() != 0) $display("FAIL disabled_pop got %0d events want 0", ev_q.size()); else n_pass++;
        enable = 1;
        p  = cyc + 1;
        dn = model_seg(r, p);
        run_to(dn + 3);
        ev_q.sort(); exp_q.sort();
        n_chk++; if (ev_q.size() != exp_q.size()) $display("FAIL resume_evcount got %0d want %0d", ev_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_chk++;
            if (ev_q[i] !== exp_q[i])
                $display("FAIL resume_ev%0d got cyc %0d kind %0d want cyc %0d kind %0d", i, ev_q[i] / 4, ev_q[i] % 4, exp_q[i] / 4, exp_q[i] % 4);
            else n_pass++;
        end
    endtask

    initial begin
        fif.fifo_empty = 1'b1;
        fif.fifo_data  = '0;
        @(posedge clk); #1;
        test_reset();
        test_single("nominal", 3, 10, 1'b1);
        test_single("min_period", 3, 3, 1'b0);
        test_single("zero_count", 0, 7, 1'b1);
        test_single("exact_floor", 2, 8, 1'b0);
        test_back_to_back();
        test_random();
        test_enable_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/segment_stepper.md
# segment_stepper

Single-axis step/direction pulse generator that sits directly downstream of the byte-to-record FIFO. It pops one 128-bit motion record at a time, decodes step count, period and direction, and emits timed step pulses on the driver pins. It reports progress and completion to the control logic.

## Interface
- RECORD_BITS, 128: width of one FIFO record (16 words × 8 bits; word 0 occupies bits [7:0]).
- PULSE_CYCLES, 4: step high time in clk cycles; must be ≥1.
- DIR_SETUP_CYCLES, 2: cycles `dir` is stable before the first step edge of a segment; must be ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  high = run; low = hold (see Operation).
- fifo_empty  in  1  FIFO has no complete record.
- fifo_data  in  RECORD_BITS  head record, combinationally valid while `fifo_empty`=0.
- fifo_read_en  out  1  pop request; FIFO advances on the same rising edge.
- step  out  1  step pulse to driver (registered).
- dir  out  1  direction to driver (registered).
- busy  out  1  segment in progress (state ≠ IDLE).
- segment_done  out  1  one-cycle pulse after a segment's last low phase.
- steps_remaining  out  32  pulses still to be issued in the current segment.

## Operation
- Record layout: [31:0] step count (unsigned); [63:32] period, cycles between consecutive step rising edges; [64] direction; [127:65] reserved, ignored.
- Pop: `fifo_read_en` = rst_n & enable & !fifo_empty & (state==IDLE), combinational. On that edge, latch count, effective period and dir, then enter DIR_SETUP.
- Effective period = max(period, 2·PULSE_CYCLES), computed in 33-bit arithmetic to avoid overflow.
- States: IDLE → DIR_SETUP (DIR_SETUP_CYCLES cycles) → STEP_HIGH (PULSE_CYCLES cycles, step=1) → STEP_LOW (period−PULSE_CYCLES cycles, step=0) → STEP_HIGH while pulses remain, else IDLE.
- Count 0: pop the record, spend DIR_SETUP, issue no pulses, then IDLE with `segment_done`. The record acts as a dir-only no-op.
- `steps_remaining`: loaded with the count at pop. Decrements on the edge that leaves STEP_HIGH.
- `enable` low:
  - IDLE: no pop.
  - DIR_SETUP/STEP_LOW: the countdown freezes.
  - STEP_HIGH: the pulse completes, then the block freezes in STEP_LOW.
  - The block never truncates a high pulse.
- `dir` changes only on a pop edge.

## Timing
- Reset values: step=0, dir=0, busy=0, segment_done=0, steps_remaining=0, state=IDLE, `fifo_read_en`=0.
- Reset mid-segment: all outputs return to reset values immediately (asynchronous). The in-flight record is discarded, not replayed.
- Pop edge E0: dir valid and busy=1 after E0. The first step rising edge occurs DIR_SETUP_CYCLES edges after E0.
- Within a segment: rising-to-rising = effective period exactly; high width = PULSE_CYCLES exactly.
- End of segment: the last STEP_LOW edge enters IDLE. `segment_done`=1 and busy=0 in that first IDLE cycle. A pop may occur in that same cycle.
- Back-to-back segments: last rising edge to next segment's first rising edge = period + 1 + DIR_SETUP_CYCLES.
- FIFO empty during IDLE: the block waits indefinitely with step=0.

## Structure
- Shared package `stepper_pkg`:
  - state enum (IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW);
  - record field offsets/widths (COUNT_LSB=0, PERIOD_LSB=32, DIR_BIT=64, FIELD_W=32).
- Sub-module `pulse_timer`: 32-bit loadable down-counter with `load`, `hold` and `zero` flag. One instance times all phases.

## Test plan
- Reset release with empty FIFO → no pop, step=0, busy=0 for 100 cycles; steps_remaining=0.
- Record {count=3, period=10, dir=1} → pop at E0, dir=1 after E0, rising edges at E0+2, +12, +22, each 4 cycles high; segment_done one cycle at E0+32; steps_remaining 3→2→1→0.
- Period=3 (below the minimum of 8) → pulses spaced 8 cycles apart, 4 cycles high.
- Count=0, dir=1 → one pop, no step edges, dir=1, segment_done 2 cycles after the pop edge.
- Two records queued {2,10,0} then {1,10,1} → second pop in the first IDLE cycle; gap between last rising edge and next = 13 cycles; dir flips on the second pop edge.
- `enable` dropped mid-pulse, then rst_n asserted during STEP_LOW:
  - high pulse completes at full width, then the block holds;
  - on reset, step/busy clear asynchronously and no further pop occurs until `fifo_empty`=0 and enable=1.
